// File: rtl/md_sched.sv
// Multiply/divide scheduler for a 5-stage MIPS pipeline: tracks HI/LO unit
// occupancy, strobes the HI/LO write-back and merges md and data stalls.
module md_sched #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_start,
  input  logic [1:0]  e_op,
  input  logic        d_md_use,
  input  logic        data_stall,
  output logic        busy,
  output logic [1:0]  op_q,
  output logic        hilo_we,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_e,
  output logic [31:0] stall_cycles
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned SC_W  = 32;

  // Cycle counts must fit the 4-bit down-counter and be non-zero.
  if (MULT_CYC < 1 || MULT_CYC > 15) begin : g_bad_mult_cyc
    $error("md_sched: MULT_CYC=%0d outside legal range 1..15", MULT_CYC);
  end
  if (DIV_CYC < 1 || DIV_CYC > 15) begin : g_bad_div_cyc
    $error("md_sched: DIV_CYC=%0d outside legal range 1..15", DIV_CYC);
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [OP_W-1:0]   r_op;
  logic [OP_W-1:0]   w_op_nxt;
  logic [SC_W-1:0]   r_stall_cycles;
  logic [SC_W-1:0]   w_stall_cycles_nxt;
  logic              w_hilo_we;
  logic              w_busy;
  logic              w_md_stall;

  // State, countdown and latched op.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
    end
  end

  // Next-state logic; e_start while busy is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_hilo_we   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (e_start) begin
          w_op_nxt    = e_op;
          w_cnt_nxt   = e_op[1] ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_hilo_we   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_busy     = (r_state == S_BUSY);
  assign w_md_stall = d_md_use & (e_start | w_busy);

  // Saturating count of md-induced stall cycles.
  always_comb begin
    w_stall_cycles_nxt = r_stall_cycles;
    if (w_md_stall && (r_stall_cycles != '1)) begin
      w_stall_cycles_nxt = r_stall_cycles + SC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else begin
      r_stall_cycles <= w_stall_cycles_nxt;
    end
  end

  assign busy         = w_busy;
  assign op_q         = r_op;
  assign hilo_we      = w_hilo_we;
  assign stall_f      = w_md_stall | data_stall;
  assign stall_d      = w_md_stall | data_stall;
  assign flush_e      = w_md_stall | data_stall;
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: a remaining-cycles model checked every
// cycle, plus hand-computed expectations for each directed scenario.
module tb_md_sched;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        e_start;
  logic [1:0]  e_op;
  logic        d_md_use;
  logic        data_stall;
  logic        busy;
  logic [1:0]  op_q;
  logic        hilo_we;
  logic        stall_f;
  logic        stall_d;
  logic        flush_e;
  logic [31:0] stall_cycles;

  md_sched #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk          (clk),
    .reset        (reset),
    .e_start      (e_start),
    .e_op         (e_op),
    .d_md_use     (d_md_use),
    .data_stall   (data_stall),
    .busy         (busy),
    .op_q         (op_q),
    .hilo_we      (hilo_we),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_e      (flush_e),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: remaining busy cycles of the running op, its op code, stall count.
  int          m_rem   = 0;
  logic [1:0]  m_op    = 2'b00;
  logic [31:0] m_sc    = 32'd0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_rem   = 0;
      m_op    = 2'b00;
      m_sc    = 32'd0;
      m_valid = 1'b1;
    end else begin
      if (d_md_use && (e_start || m_rem > 0) && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (m_rem > 0) m_rem = m_rem - 1;
      else if (e_start) begin
        m_rem = e_op[1] ? DIV_N : MULT_N;
        m_op  = e_op;
      end
    end
  end

  // Observation counters for the directed literal checks.
  int cyc_n     = 0;
  int n_busy    = 0;
  int n_hilo    = 0;
  int last_hilo = -100;
  int prev_hilo = -100;

  always @(negedge clk) begin
    logic exp_busy, exp_stall;
    cyc_n++;
    if (m_valid) begin
      exp_busy  = (m_rem > 0);
      exp_stall = (d_md_use && (e_start || exp_busy)) || data_stall;
      chk("busy",         32'(busy),    32'(exp_busy));
      chk("op_q",         32'(op_q),    32'(m_op));
      chk("hilo_we",      32'(hilo_we), 32'(m_rem == 1));
      chk("stall_f",      32'(stall_f), 32'(exp_stall));
      chk("stall_d",      32'(stall_d), 32'(exp_stall));
      chk("flush_e",      32'(flush_e), 32'(exp_stall));
      chk("stall_cycles", stall_cycles, m_sc);
    end
    if (busy === 1'b1) n_busy++;
    if (hilo_we === 1'b1) begin
      n_hilo++;
      prev_hilo = last_hilo;
      last_hilo = cyc_n;
    end
  end

  task automatic cyc(input logic es, input logic [1:0] op, input logic du,
                     input logic ds, input logic rs);
    e_start    = es;
    e_op       = op;
    d_md_use   = du;
    data_stall = ds;
    reset      = rs;
    @(posedge clk);
    #1;
  endtask

  int b0, h0;
  logic [31:0] sc0;

  initial begin
    reset = 1'b1; e_start = 1'b0; e_op = 2'b00; d_md_use = 1'b0; data_stall = 1'b0;
    cyc(0, 2'b00, 0, 0, 1);
    cyc(0, 2'b00, 0, 0, 1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sc",   stall_cycles, 32'd0);
    chk("reset_op",   32'(op_q), 32'd0);

    // 1: mult, no D-stage user: 5 busy cycles, one write strobe, no stall
    b0 = n_busy; h0 = n_hilo;
    cyc(1, 2'b00, 0, 0, 0);
    repeat (6) cyc(0, 2'b00, 0, 0, 0);
    chk("t1_busy_len", 32'(n_busy - b0), 32'd5);
    chk("t1_hilo_cnt", 32'(n_hilo - h0), 32'd1);
    chk("t1_sc",       stall_cycles, 32'd0);

    // 2: div with D-stage user held: 11 stall cycles, released afterwards
    cyc(1, 2'b10, 1, 0, 0);
    repeat (10) cyc(0, 2'b00, 1, 0, 0);
    chk("t2_release_stall", 32'(stall_f), 32'd0);
    cyc(0, 2'b00, 1, 0, 0);
    chk("t2_sc", stall_cycles, 32'd11);
    chk("t2_op", 32'(op_q), 32'd2);

    // 3: mult, mflo waits, multu re-issued in the release cycle
    b0 = n_busy; h0 = n_hilo;
    cyc(1, 2'b00, 0, 0, 0);
    repeat (5) cyc(0, 2'b00, 1, 0, 0);
    cyc(1, 2'b01, 1, 0, 0);
    repeat (6) cyc(0, 2'b00, 0, 0, 0);
    chk("t3_hilo_gap", 32'(last_hilo - prev_hilo), 32'd6);
    chk("t3_hilo_cnt", 32'(n_hilo - h0), 32'd2);
    chk("t3_busy_len", 32'(n_busy - b0), 32'd10);
    chk("t3_op",       32'(op_q), 32'd1);
    chk("t3_sc",       stall_cycles, 32'd17);

    // 4: reset during the 3rd busy cycle of a div aborts it
    h0 = n_hilo;
    cyc(1, 2'b10, 0, 0, 0);
    cyc(0, 2'b00, 1, 0, 0);
    cyc(0, 2'b00, 1, 0, 0);
    cyc(1, 2'b11, 1, 0, 1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_sc",   stall_cycles, 32'd0);
    chk("t4_stall_es", 32'(stall_f), 32'd1);
    cyc(0, 2'b00, 1, 0, 0);
    chk("t4_stall_idle", 32'(stall_f), 32'd0);
    repeat (12) cyc(0, 2'b00, 0, 0, 0);
    chk("t4_no_hilo", 32'(n_hilo - h0), 32'd0);

    // 5: data_stall alone stalls but is not counted
    sc0 = stall_cycles;
    repeat (3) cyc(0, 2'b00, 0, 1, 0);
    chk("t5_stall_f",  32'(stall_f), 32'd1);
    chk("t5_flush_e",  32'(flush_e), 32'd1);
    chk("t5_sc",       stall_cycles, sc0);

    // 6: forced e_start (divu) mid-busy leaves op and duration untouched
    b0 = n_busy; h0 = n_hilo;
    cyc(1, 2'b00, 0, 0, 0);
    cyc(0, 2'b00, 0, 0, 0);
    cyc(1, 2'b11, 0, 0, 0);
    chk("t6_op_mid", 32'(op_q), 32'd0);
    cyc(1, 2'b11, 0, 0, 0);
    repeat (3) cyc(0, 2'b00, 0, 0, 0);
    chk("t6_busy_len", 32'(n_busy - b0), 32'd5);
    chk("t6_hilo_cnt", 32'(n_hilo - h0), 32'd1);
    chk("t6_op_end",   32'(op_q), 32'd0);

    repeat (2) cyc(0, 2'b00, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
